// File: rtl/line_memory_if.sv
// Cache-side request/acknowledge bundle for line_memory.
// The cache drives the master modport and the memory model drives the slave modport.
interface line_memory_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              enable_i;
  logic              write_i;
  logic [ADDR_W-1:0] addr_i;
  logic [LINE_W-1:0] data_i;
  logic [LINE_W-1:0] data_o;
  logic              ack_o;
  logic              busy_o;

  modport master (
    output enable_i, write_i, addr_i, data_i,
    input  data_o, ack_o, busy_o
  );

  modport slave (
    input  enable_i, write_i, addr_i, data_i,
    output data_o, ack_o, busy_o
  );
endinterface

// File: rtl/line_memory.sv
// Whole-line off-chip data memory model with a fixed-latency, single-pulse acknowledge.
// Optional macro LINE_MEMORY_STATS_EN adds saturating read/write completion counters.
module line_memory #(
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
)(
  input  logic         clk_i,
  input  logic         rst_i,
  line_memory_if.slave bus
`ifdef LINE_MEMORY_STATS_EN
  ,
  output logic [31:0]  rd_count_o,
  output logic [31:0]  wr_count_o
`endif
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam int         IDX_HI   = IDX_W + 4;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [7:0]        r_count;
  logic [IDX_W-1:0]  r_lineIdx;
  logic              r_write;
  logic [LINE_W-1:0] r_writeData;
  logic [LINE_W-1:0] r_readData;
  logic [LINE_W-1:0] r_mem [DEPTH];
  logic              w_accept;
  logic              w_complete;
  logic              w_unusedAddr;

  // Byte offset and the aliased upper address bits never select storage.
  assign w_unusedAddr = ^{bus.addr_i[ADDR_W-1:IDX_HI+1], bus.addr_i[4:0]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The IDLE cycle whose closing edge accepts is cycle 0; the counter then
  // walks LATENCY-1 down to 1 so ACK lands in cycle LATENCY.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.enable_i) begin
          w_accept    = 1'b1;
          w_nextState = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_count == 8'd1) begin
          w_complete  = 1'b1;
          w_nextState = S_ACK;
        end
      end
      S_ACK: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count     <= 8'd0;
      r_lineIdx   <= '0;
      r_write     <= 1'b0;
      r_writeData <= '0;
    end else if (w_accept) begin
      r_count     <= CNT_LOAD;
      r_lineIdx   <= bus.addr_i[IDX_HI:5];
      r_write     <= bus.write_i;
      r_writeData <= bus.data_i;
    end else if (r_state == S_WAIT) begin
      r_count     <= r_count - 8'd1;
    end
  end

  // Storage has no reset so it behaves like a RAM and survives rst_i.
  always_ff @(posedge clk_i) begin
    if (w_complete && r_write) begin
      r_mem[r_lineIdx] <= r_writeData;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_readData <= '0;
    end else if (w_complete && !r_write) begin
      r_readData <= r_mem[r_lineIdx];
    end
  end

  assign bus.data_o = r_readData;
  assign bus.ack_o  = (r_state == S_ACK);
  assign bus.busy_o = (r_state != S_IDLE);

`ifdef LINE_MEMORY_STATS_EN
  logic [31:0] r_rdCount;
  logic [31:0] r_wrCount;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rdCount <= 32'd0;
      r_wrCount <= 32'd0;
    end else if (w_complete) begin
      if (r_write) begin
        if (r_wrCount != 32'hFFFF_FFFF) begin
          r_wrCount <= r_wrCount + 32'd1;
        end
      end else begin
        if (r_rdCount != 32'hFFFF_FFFF) begin
          r_rdCount <= r_rdCount + 32'd1;
        end
      end
    end
  end

  assign rd_count_o = r_rdCount;
  assign wr_count_o = r_wrCount;
`endif

endmodule
